hazard_forward_unit: RTL and testbench

Parametrised successor to the combinational EX/MEM/WB forwarding selector. Adds NUM_SRC forwarded EX operands, load-use stall detection, and a scoreboard that tracks in-flight long-latency ops (multi-cycle unit, fixed LONG_LAT). Produces IF/ID hold, ID/EX bubble, and a long-unit forward path. Sits between decode and the EX operand muxes.

---
 rtl/hazard_forward_unit.sv | 216 +++++++++++++++++++++
 tb/tb_hazard_forward_unit.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   Operand forwarding selector and hazard detector between decode and the EX operand muxes.
//   Tracks in-flight long-latency ops in a small scoreboard so that dependent instructions
//   are held in decode until the long unit can forward the result directly.
//
// Optional build macro: HAZARD_PERF_EN adds saturating stall-cycle counters. Without it the
//   counter outputs are tied to zero and no counter flops exist.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   id_src_vec/used       decode-stage source registers and per-slot "read" flags
//   id_regwrite/dest_reg  decode instruction writes RF / its destination
//   id_long_issue         decode instruction is a long-latency op
//   flush                 squash decode instruction (masks stalls and allocation)
//   id_ex_memread/dest    EX instruction is a load / its destination
//   ex_src_vec            EX-stage source registers to forward
//   ex_mem_*              MEM-stage write / store info
//   mem_wb_*              WB-stage write info
//   forward_sel           per-slot mux: 00 RF, 01 EX/MEM, 10 MEM/WB, 11 long unit
//   forward_mem           01 = WB-to-MEM store-data bypass
//   stall_if_id           hold PC and IF/ID
//   bubble_id_ex          insert NOP into ID/EX
//   sb_full               every scoreboard entry is valid
//   stall_loaduse_cnt     load-use stall cycles (HAZARD_PERF_EN)
//   stall_long_cnt        scoreboard stall cycles (HAZARD_PERF_EN)
module hazard_forward_unit #(
    parameter int unsigned REG_ADDR = 5,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned LONG_LAT = 4,
    parameter int unsigned SB_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC*REG_ADDR-1:0] id_src_vec,
    input  logic [NUM_SRC-1:0]          id_src_used,
    input  logic                        id_regwrite,
    input  logic [REG_ADDR-1:0]         id_dest_reg,
    input  logic                        id_long_issue,
    input  logic                        flush,
    input  logic                        id_ex_memread,
    input  logic [REG_ADDR-1:0]         id_ex_dest_reg,
    input  logic [NUM_SRC*REG_ADDR-1:0] ex_src_vec,
    input  logic                        ex_mem_regwrite,
    input  logic [REG_ADDR-1:0]         ex_mem_dest_reg,
    input  logic                        ex_mem_writemem,
    input  logic [REG_ADDR-1:0]         ex_mem_store_src,
    input  logic                        mem_wb_regwrite,
    input  logic [REG_ADDR-1:0]         mem_wb_dest_reg,
    output logic [2*NUM_SRC-1:0]        forward_sel,
    output logic [1:0]                  forward_mem,
    output logic                        stall_if_id,
    output logic                        bubble_id_ex,
    output logic                        sb_full,
    output logic [15:0]                 stall_loaduse_cnt,
    output logic [15:0]                 stall_long_cnt
);

    localparam int unsigned CNT_W = $clog2(LONG_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LONG_LAT);

    // Scoreboard state
    logic [SB_DEPTH-1:0]               sb_valid_q, sb_valid_d;
    logic [SB_DEPTH-1:0][REG_ADDR-1:0] sb_dest_q, sb_dest_d;
    logic [SB_DEPTH-1:0][CNT_W-1:0]    sb_cnt_q, sb_cnt_d;

    logic [SB_DEPTH-1:0] alloc_sel;
    logic                alloc_en;

    logic hz_loaduse, hz_raw_long, hz_waw, hz_struct;
    logic stall_loaduse, stall_long;

    assign sb_full = &sb_valid_q;

    // ------------------------------------------------------------------
    // Decode-stage hazard detection
    // ------------------------------------------------------------------
    always_comb begin
        hz_loaduse  = 1'b0;
        hz_raw_long = 1'b0;
        hz_waw      = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (id_src_used[s] && (id_src_vec[s*REG_ADDR +: REG_ADDR] != '0)) begin
                if (id_ex_memread && (id_ex_dest_reg == id_src_vec[s*REG_ADDR +: REG_ADDR])) begin
                    hz_loaduse = 1'b1;
                end
                // Count >= 3: the long result cannot reach the EX forward path in time yet.
                for (int e = 0; e < SB_DEPTH; e++) begin
                    if (sb_valid_q[e] && (sb_dest_q[e] == id_src_vec[s*REG_ADDR +: REG_ADDR]) &&
                        (sb_cnt_q[e] >= CNT_W'(3))) begin
                        hz_raw_long = 1'b1;
                    end
                end
            end
        end
        // Count >= 2: a younger write would otherwise be overtaken by the long result.
        if (id_regwrite && (id_dest_reg != '0)) begin
            for (int e = 0; e < SB_DEPTH; e++) begin
                if (sb_valid_q[e] && (sb_dest_q[e] == id_dest_reg) &&
                    (sb_cnt_q[e] >= CNT_W'(2))) begin
                    hz_waw = 1'b1;
                end
            end
        end
    end

    assign hz_struct     = id_long_issue && sb_full;
    assign stall_loaduse = hz_loaduse && !flush;
    assign stall_long    = (hz_raw_long || hz_waw || hz_struct) && !flush;
    assign stall_if_id   = stall_loaduse || stall_long;
    assign bubble_id_ex  = stall_if_id;

    // ------------------------------------------------------------------
    // EX operand forwarding
    // ------------------------------------------------------------------
    always_comb begin
        forward_sel = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (ex_src_vec[s*REG_ADDR +: REG_ADDR] != '0) begin
                if (ex_mem_regwrite &&
                    (ex_mem_dest_reg == ex_src_vec[s*REG_ADDR +: REG_ADDR])) begin
                    forward_sel[2*s +: 2] = 2'b01;
                end else begin
                    for (int e = 0; e < SB_DEPTH; e++) begin
                        if (sb_valid_q[e] && (sb_cnt_q[e] == CNT_W'(1)) &&
                            (sb_dest_q[e] == ex_src_vec[s*REG_ADDR +: REG_ADDR])) begin
                            forward_sel[2*s +: 2] = 2'b11;
                        end
                    end
                    if ((forward_sel[2*s +: 2] == 2'b00) && mem_wb_regwrite &&
                        (mem_wb_dest_reg == ex_src_vec[s*REG_ADDR +: REG_ADDR])) begin
                        forward_sel[2*s +: 2] = 2'b10;
                    end
                end
            end
        end
    end

    assign forward_mem = (mem_wb_regwrite && ex_mem_writemem && (mem_wb_dest_reg != '0) &&
                          (mem_wb_dest_reg == ex_mem_store_src)) ? 2'b01 : 2'b00;

    // ------------------------------------------------------------------
    // Scoreboard allocation and countdown
    // ------------------------------------------------------------------
    // Descending scan so the lowest free index wins.
    always_comb begin
        alloc_sel = '0;
        for (int e = SB_DEPTH - 1; e >= 0; e--) begin
            if (!sb_valid_q[e]) begin
                alloc_sel    = '0;
                alloc_sel[e] = 1'b1;
            end
        end
    end

    assign alloc_en = id_long_issue && !stall_if_id && !flush && (id_dest_reg != '0);

    // An entry retiring this cycle is still valid, so it is never picked by alloc_sel.
    always_comb begin
        sb_valid_d = sb_valid_q;
        sb_dest_d  = sb_dest_q;
        sb_cnt_d   = sb_cnt_q;
        for (int e = 0; e < SB_DEPTH; e++) begin
            if (sb_valid_q[e]) begin
                sb_cnt_d[e] = sb_cnt_q[e] - CNT_W'(1);
                if (sb_cnt_q[e] == CNT_W'(1)) begin
                    sb_valid_d[e] = 1'b0;
                end
            end
            if (alloc_en && alloc_sel[e]) begin
                sb_valid_d[e] = 1'b1;
                sb_dest_d[e]  = id_dest_reg;
                sb_cnt_d[e]   = CNT_INIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_valid_q <= '0;
            sb_dest_q  <= '0;
            sb_cnt_q   <= '0;
        end else begin
            sb_valid_q <= sb_valid_d;
            sb_dest_q  <= sb_dest_d;
            sb_cnt_q   <= sb_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Stall performance counters
    // ------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
    logic [15:0] lu_cnt_q, long_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt_q   <= '0;
            long_cnt_q <= '0;
        end else begin
            if (stall_loaduse && (lu_cnt_q != 16'hFFFF)) begin
                lu_cnt_q <= lu_cnt_q + 16'd1;
            end
            if (stall_long && (long_cnt_q != 16'hFFFF)) begin
                long_cnt_q <= long_cnt_q + 16'd1;
            end
        end
    end

    assign stall_loaduse_cnt = lu_cnt_q;
    assign stall_long_cnt    = long_cnt_q;
`else
    assign stall_loaduse_cnt = 16'h0000;
    assign stall_long_cnt    = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

    logic        clk;
    logic        rst_n;
    logic [9:0]  id_src_vec;
    logic [1:0]  id_src_used;
    logic        id_regwrite;
    logic [4:0]  id_dest_reg;
    logic        id_long_issue;
    logic        flush;
    logic        id_ex_memread;
    logic [4:0]  id_ex_dest_reg;
    logic [9:0]  ex_src_vec;
    logic        ex_mem_regwrite;
    logic [4:0]  ex_mem_dest_reg;
    logic        ex_mem_writemem;
    logic [4:0]  ex_mem_store_src;
    logic        mem_wb_regwrite;
    logic [4:0]  mem_wb_dest_reg;
    logic [3:0]  forward_sel;
    logic [1:0]  forward_mem;
    logic        stall_if_id;
    logic        bubble_id_ex;
    logic        sb_full;
    logic [15:0] stall_loaduse_cnt;
    logic [15:0] stall_long_cnt;

    int n_cmp;
    int n_fail;

    hazard_forward_unit #(
        .REG_ADDR(5),
        .NUM_SRC (2),
        .LONG_LAT(4),
        .SB_DEPTH(4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_src_vec       (id_src_vec),
        .id_src_used      (id_src_used),
        .id_regwrite      (id_regwrite),
        .id_dest_reg      (id_dest_reg),
        .id_long_issue    (id_long_issue),
        .flush            (flush),
        .id_ex_memread    (id_ex_memread),
        .id_ex_dest_reg   (id_ex_dest_reg),
        .ex_src_vec       (ex_src_vec),
        .ex_mem_regwrite  (ex_mem_regwrite),
        .ex_mem_dest_reg  (ex_mem_dest_reg),
        .ex_mem_writemem  (ex_mem_writemem),
        .ex_mem_store_src (ex_mem_store_src),
        .mem_wb_regwrite  (mem_wb_regwrite),
        .mem_wb_dest_reg  (mem_wb_dest_reg),
        .forward_sel      (forward_sel),
        .forward_mem      (forward_mem),
        .stall_if_id      (stall_if_id),
        .bubble_id_ex     (bubble_id_ex),
        .sb_full          (sb_full),
        .stall_loaduse_cnt(stall_loaduse_cnt),
        .stall_long_cnt   (stall_long_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic clr_inputs();
        id_src_vec       = '0;
        id_src_used      = '0;
        id_regwrite      = 1'b0;
        id_dest_reg      = '0;
        id_long_issue    = 1'b0;
        flush            = 1'b0;
        id_ex_memread    = 1'b0;
        id_ex_dest_reg   = '0;
        ex_src_vec       = '0;
        ex_mem_regwrite  = 1'b0;
        ex_mem_dest_reg  = '0;
        ex_mem_writemem  = 1'b0;
        ex_mem_store_src = '0;
        mem_wb_regwrite  = 1'b0;
        mem_wb_dest_reg  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        clr_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clr_inputs();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (sb_full !== 1'b0) begin
            n_fail++; $display("FAIL reset_sb_full: got %b required 0", sb_full);
        end
        n_cmp++;
        if ({stall_if_id, bubble_id_ex} !== 2'b00) begin
            n_fail++; $display("FAIL reset_stall: got %b%b required 00", stall_if_id, bubble_id_ex);
        end
        n_cmp++;
        if ({forward_sel, forward_mem} !== 6'b0) begin
            n_fail++; $display("FAIL reset_fwd: got %b/%b required 0000/00", forward_sel, forward_mem);
        end
        n_cmp++;
        if ({stall_loaduse_cnt, stall_long_cnt} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %h/%h required 0/0", stall_loaduse_cnt, stall_long_cnt);
        end
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_forward();
        apply_reset();
        ex_mem_regwrite = 1'b1; ex_mem_dest_reg = 5'd3;
        mem_wb_regwrite = 1'b1; mem_wb_dest_reg = 5'd3;
        ex_src_vec = {5'd0, 5'd3};
        #1;
        n_cmp++;
        if (forward_sel !== 4'b0001) begin
            n_fail++; $display("FAIL fwd_exmem: got %b required 0001", forward_sel);
        end
        ex_mem_regwrite = 1'b0;
        #1;
        n_cmp++;
        if (forward_sel !== 4'b0010) begin
            n_fail++; $display("FAIL fwd_memwb: got %b required 0010", forward_sel);
        end
        ex_src_vec = {5'd3, 5'd3};
        ex_mem_regwrite = 1'b1; ex_mem_dest_reg = 5'd4; mem_wb_dest_reg = 5'd3;
        #1;
        n_cmp++;
        if (forward_sel !== 4'b1010) begin
            n_fail++; $display("FAIL fwd_both_slots: got %b required 1010", forward_sel);
        end
        ex_src_vec = '0; ex_mem_dest_reg = '0; mem_wb_dest_reg = '0;
        #1;
        n_cmp++;
        if (forward_sel !== 4'b0000) begin
            n_fail++; $display("FAIL fwd_r0: got %b required 0000", forward_sel);
        end
        mem_wb_dest_reg = 5'd6; ex_mem_writemem = 1'b1; ex_mem_store_src = 5'd6;
        #1;
        n_cmp++;
        if (forward_mem !== 2'b01) begin
            n_fail++; $display("FAIL fwd_mem_bypass: got %b required 01", forward_mem);
        end
        mem_wb_dest_reg = 5'd0; ex_mem_store_src = 5'd0;
        #1;
        n_cmp++;
        if (forward_mem !== 2'b00) begin
            n_fail++; $display("FAIL fwd_mem_r0: got %b required 00", forward_mem);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        id_ex_memread = 1'b1; id_ex_dest_reg = 5'd5;
        id_src_vec = {5'd5, 5'd0}; id_src_used = 2'b11;
        #1;
        n_cmp++;
        if ({stall_if_id, bubble_id_ex} !== 2'b11) begin
            n_fail++; $display("FAIL lu_stall: got %b%b required 11", stall_if_id, bubble_id_ex);
        end
        tick();
        // the bubble now sits in EX
        id_ex_memread = 1'b0; id_ex_dest_reg = 5'd0;
        #1;
        n_cmp++;
        if ({stall_if_id, bubble_id_ex} !== 2'b00) begin
            n_fail++; $display("FAIL lu_one_cycle: got %b%b required 00", stall_if_id, bubble_id_ex);
        end
        id_ex_memread = 1'b1; id_ex_dest_reg = 5'd5; id_src_used = 2'b01;
        #1;
        n_cmp++;
        if (stall_if_id !== 1'b0) begin
            n_fail++; $display("FAIL lu_unused_slot: got %b required 0", stall_if_id);
        end
        id_ex_dest_reg = 5'd0; id_src_vec = '0; id_src_used = 2'b11;
        #1;
        n_cmp++;
        if (stall_if_id !== 1'b0) begin
            n_fail++; $display("FAIL lu_r0: got %b required 0", stall_if_id);
        end
`ifndef HAZARD_PERF_EN
        n_cmp++;
        if ({stall_loaduse_cnt, stall_long_cnt} !== 32'h0) begin
            n_fail++;
            $display("FAIL cnt_tied_zero: got %h/%h required 0/0", stall_loaduse_cnt, stall_long_cnt);
        end
`endif
    endtask

    task automatic test_long_latency();
        apply_reset();
        // cycle T
        id_long_issue = 1'b1; id_dest_reg = 5'd7;
        #1;
        n_cmp++;
        if (stall_if_id !== 1'b0) begin
            n_fail++; $display("FAIL long_issue: got %b required 0", stall_if_id);
        end
        tick();
        // T+1, count 4
        id_long_issue = 1'b0; id_dest_reg = 5'd0;
        id_src_vec = {5'd0, 5'd7}; id_src_used = 2'b01;
        #1;
        n_cmp++;
        if ({stall_if_id, bubble_id_ex} !== 2'b11) begin
            n_fail++; $display("FAIL long_raw_t1: got %b%b required 11", stall_if_id, bubble_id_ex);
        end
        tick();
        // T+2, count 3
        n_cmp++;
        if (stall_if_id !== 1'b1) begin
            n_fail++; $display("FAIL long_raw_t2: got %b required 1", stall_if_id);
        end
        tick();
        // T+3, count 2
        n_cmp++;
        if (stall_if_id !== 1'b0) begin
            n_fail++; $display("FAIL long_adv_t3: got %b required 0", stall_if_id);
        end
        id_regwrite = 1'b1; id_dest_reg = 5'd7;
        #1;
        n_cmp++;
        if (stall_if_id !== 1'b1) begin
            n_fail++; $display("FAIL long_waw_t3: got %b required 1", stall_if_id);
        end
        id_regwrite = 1'b0; id_dest_reg = 5'd0;
        tick();
        // T+4, count 1
        ex_src_vec = {5'd0, 5'd7}; mem_wb_regwrite = 1'b1; mem_wb_dest_reg = 5'd7;
        #1;
        n_cmp++;
        if (forward_sel !== 4'b0011) begin
            n_fail++; $display("FAIL long_fwd_t4: got %b required 0011", forward_sel);
        end
        ex_mem_regwrite = 1'b1; ex_mem_dest_reg = 5'd7;
        #1;
        n_cmp++;
        if (forward_sel !== 4'b0001) begin
            n_fail++; $display("FAIL long_exmem_prio: got %b required 0001", forward_sel);
        end
        ex_mem_regwrite = 1'b0; mem_wb_regwrite = 1'b0;
        id_regwrite = 1'b1; id_dest_reg = 5'd7;
        #1;
        n_cmp++;
        if (stall_if_id !== 1'b0) begin
            n_fail++; $display("FAIL long_t4_nostall: got %b required 0", stall_if_id);
        end
        tick();
        // T+5, entry gone
        n_cmp++;
        if ({forward_sel, stall_if_id} !== 5'b0) begin
            n_fail++;
            $display("FAIL long_retired: got fwd %b stall %b required 0000/0", forward_sel, stall_if_id);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            id_long_issue = 1'b1; id_dest_reg = 5'(10 + i);
            #1;
            n_cmp++;
            if ({stall_if_id, sb_full} !== 2'b00) begin
                n_fail++;
                $display("FAIL b2b_issue%0d: got stall %b full %b required 0/0", i, stall_if_id, sb_full);
            end
            tick();
        end
        // A+4: entry counts 1,2,3,4
        id_dest_reg = 5'd14; ex_src_vec = {5'd0, 5'd10};
        #1;
        n_cmp++;
        if ({sb_full, stall_if_id, bubble_id_ex} !== 3'b111) begin
            n_fail++;
            $display("FAIL b2b_struct: got full %b stall %b bubble %b required 1/1/1",
                     sb_full, stall_if_id, bubble_id_ex);
        end
        n_cmp++;
        if (forward_sel !== 4'b0011) begin
            n_fail++; $display("FAIL b2b_fwd_e0: got %b required 0011", forward_sel);
        end
        tick();
        // A+5: oldest retired, fifth issue proceeds
        ex_src_vec = {5'd11, 5'd0};
        #1;
        n_cmp++;
        if ({sb_full, stall_if_id} !== 2'b00) begin
            n_fail++; $display("FAIL b2b_5th_go: got full %b stall %b required 0/0", sb_full, stall_if_id);
        end
        n_cmp++;
        if (forward_sel !== 4'b1100) begin
            n_fail++; $display("FAIL b2b_fwd_e1: got %b required 1100", forward_sel);
        end
        tick();
        // A+6: r14 freshly allocated, r12 at count 1
        id_long_issue = 1'b0; id_dest_reg = 5'd0;
        ex_src_vec = {5'd0, 5'd12}; id_src_vec = {5'd0, 5'd14}; id_src_used = 2'b01;
        #1;
        n_cmp++;
        if ({sb_full, stall_if_id, forward_sel} !== 6'b0_1_0011) begin
            n_fail++;
            $display("FAIL b2b_a6: got full %b stall %b fwd %b required 0/1/0011",
                     sb_full, stall_if_id, forward_sel);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        id_long_issue = 1'b1; id_dest_reg = 5'd7;
        tick();
        // B+1: r7 count 4; flushed long issue with RAW and load-use matches
        id_dest_reg = 5'd9; flush = 1'b1;
        id_src_vec = {5'd0, 5'd7}; id_src_used = 2'b01;
        id_ex_memread = 1'b1; id_ex_dest_reg = 5'd7;
        #1;
        n_cmp++;
        if ({stall_if_id, bubble_id_ex} !== 2'b00) begin
            n_fail++; $display("FAIL flush_mask: got %b%b required 00", stall_if_id, bubble_id_ex);
        end
        tick();
        // B+2
        flush = 1'b0; id_long_issue = 1'b0; id_dest_reg = 5'd0;
        id_ex_memread = 1'b0; id_ex_dest_reg = 5'd0;
        id_src_vec = {5'd0, 5'd9};
        #1;
        n_cmp++;
        if (stall_if_id !== 1'b0) begin
            n_fail++; $display("FAIL flush_noalloc: got %b required 0", stall_if_id);
        end
        id_src_vec = {5'd0, 5'd7};
        #1;
        n_cmp++;
        if (stall_if_id !== 1'b1) begin
            n_fail++; $display("FAIL flush_keep: got %b required 1", stall_if_id);
        end
        tick();
        tick();
        // B+4: r7 at count 1
        id_src_used = 2'b00; ex_src_vec = {5'd7, 5'd0};
        #1;
        n_cmp++;
        if (forward_sel !== 4'b1100) begin
            n_fail++; $display("FAIL flush_fwd: got %b required 1100", forward_sel);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        id_long_issue = 1'b1; id_dest_reg = 5'd20;
        tick();
        id_dest_reg = 5'd21;
        tick();
        id_long_issue = 1'b0; id_dest_reg = 5'd0;
        id_src_vec = {5'd0, 5'd20}; id_src_used = 2'b01;
        #1;
        n_cmp++;
        if (stall_if_id !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre: got %b required 1", stall_if_id);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({stall_if_id, sb_full} !== 2'b00) begin
            n_fail++; $display("FAIL rstmid_clear: got stall %b full %b required 0/0", stall_if_id, sb_full);
        end
        tick();
        rst_n = 1'b1;
        id_src_vec = {5'd21, 5'd20}; id_src_used = 2'b11;
        #1;
        n_cmp++;
        if (stall_if_id !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_after: got %b required 0", stall_if_id);
        end
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        apply_reset();
        id_ex_memread = 1'b1; id_ex_dest_reg = 5'd5;
        id_src_vec = {5'd0, 5'd5}; id_src_used = 2'b01;
        tick(); tick(); tick();
        clr_inputs();
        #1;
        n_cmp++;
        if ({stall_loaduse_cnt, stall_long_cnt} !== {16'd3, 16'd0}) begin
            n_fail++;
            $display("FAIL perf_lu3: got %0d/%0d required 3/0", stall_loaduse_cnt, stall_long_cnt);
        end
        id_long_issue = 1'b1; id_dest_reg = 5'd7;
        tick();
        id_long_issue = 1'b0; id_dest_reg = 5'd0;
        id_src_vec = {5'd0, 5'd7}; id_src_used = 2'b01;
        tick(); tick();
        clr_inputs();
        #1;
        n_cmp++;
        if ({stall_loaduse_cnt, stall_long_cnt} !== {16'd3, 16'd2}) begin
            n_fail++;
            $display("FAIL perf_long2: got %0d/%0d required 3/2", stall_loaduse_cnt, stall_long_cnt);
        end
        id_ex_memread = 1'b1; id_ex_dest_reg = 5'd5;
        id_src_vec = {5'd0, 5'd5}; id_src_used = 2'b01;
        repeat (65540) tick();
        n_cmp++;
        if ({stall_loaduse_cnt, stall_long_cnt} !== {16'hFFFF, 16'd2}) begin
            n_fail++;
            $display("FAIL perf_sat: got %h/%h required FFFF/0002", stall_loaduse_cnt, stall_long_cnt);
        end
        clr_inputs();
        id_long_issue = 1'b1; id_dest_reg = 5'd8;
        tick();
        id_long_issue = 1'b0; id_dest_reg = 5'd0;
        id_src_vec = {5'd0, 5'd8}; id_src_used = 2'b01;
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({stall_loaduse_cnt, stall_long_cnt, sb_full, stall_if_id} !== 34'b0) begin
            n_fail++;
            $display("FAIL perf_rst: got %h/%h full %b stall %b required 0/0/0/0",
                     stall_loaduse_cnt, stall_long_cnt, sb_full, stall_if_id);
        end
        tick();
        rst_n = 1'b1;
        #1;
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        clr_inputs();
        test_reset();
        test_forward();
        test_load_use();
        test_long_latency();
        test_back_to_back();
        test_flush();
        test_reset_mid();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
